uart_tlul_bridge: RTL
=====================

Name: uart_tlul_bridge

Overview:
- TileLink-UL device-side adapter in front of uart_core: converts TL-UL A/D channel transactions into uart_core single-cycle register strobes.
- Drives reg_addr/reg_wdata/reg_we/reg_re and captures reg_rdata, which uart_core registers and returns RD_LAT cycles after reg_re.
- One outstanding transaction; protocol violations are returned as d_error, never forwarded.

Parameters:
- SRC_W, 8, width of a_source/d_source.
- RD_LAT, 1, cycles from reg_re asserted to reg_rdata valid (1..3).
- BASE_ADDR, 32'h4000_0000, UART window base; upper 20 bits compared when the optional feature is on.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- a_valid_i  in  1  A-channel valid
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_size_i  in  2  log2 bytes
- a_address_i  in  32  byte address
- a_mask_i  in  4  byte lanes
- a_data_i  in  32  write data
- a_source_i  in  SRC_W  transaction ID
- a_ready_o  out  1  A-channel ready
- d_valid_o  out  1  D-channel valid
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- d_size_o  out  2  echoed a_size
- d_source_o  out  SRC_W  echoed a_source
- d_data_o  out  32  read data
- d_error_o  out  1  error response
- d_ready_i  in  1  D-channel ready
- reg_addr_o  out  12  to uart_core reg_addr
- reg_wdata_o  out  32  to uart_core reg_wdata
- reg_we_o  out  1  write strobe
- reg_re_o  out  1  read strobe
- reg_rdata_i  in  32  from uart_core reg_rdata

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset values: a_ready_o=1; d_valid_o, d_error_o, reg_we_o, reg_re_o=0; all data, address, ID and opcode outputs = 0; state=IDLE.
- All outputs are registered except a_ready_o, which is 1 exactly when state==IDLE.
- States: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE:
  - Accept when a_valid_i. Latch opcode, size, source, address[11:0], data.
  - Error check; any one condition sets err:
    - opcode not in {0,1,4}
    - a_size_i != 2
    - address[1:0] != 0
    - Put with mask != 4'hF
  - err -> RESP with d_error=1, d_data=0, no strobe; d_valid_o asserted the cycle after accept.
  - no err -> ACCESS.
- ACCESS:
  - Exactly one cycle of reg_we_o (Put) or reg_re_o (Get).
  - reg_addr_o = address[11:0]; reg_wdata_o = a_data.
  - Put -> RESP: d_valid 2 cycles after accept.
  - Get -> WAIT_RD.
- WAIT_RD:
  - Count RD_LAT cycles, then capture reg_rdata_i into d_data_o and go to RESP.
  - With RD_LAT=1, d_valid is asserted 3 cycles after accept.
- RESP:
  - d_valid_o held with all D fields stable until d_ready_i.
  - d_opcode = 1 for Get (including errored Get), else 0.
  - On d_valid_o & d_ready_i -> IDLE. a_ready_o=1 the following cycle; back-to-back accept is possible then.
- Strobes:
  - reg_we_o and reg_re_o are never both high.
  - Each is high at most one cycle per transaction.
  - reg_addr_o and reg_wdata_o hold their value outside ACCESS.
- Simultaneous events: a_valid_i while not IDLE is ignored (a_ready_o=0). d_ready_i while d_valid_o=0 has no effect.
- Reset mid-operation: transaction dropped, strobes deasserted immediately (async), no response issued.

Optional Feature:
- Macro: UART_TLUL_ADDR_CHECK_EN.
- Defined: a_address_i[31:12] != BASE_ADDR[31:12] is an additional error condition (error response, no strobe).
- Undefined: upper address bits are ignored and only [11:0] is used.

Decomposition:
- Package uart_tlul_pkg:
  - tl_a_op_e (PutFullData=0, PutPartialData=1, Get=4)
  - tl_d_op_e (AccessAck=0, AccessAckData=1)
  - bridge state enum
  - UART_REG_AW=12
- No sub-module: a single FSM is natural.
- The uart_core address map constants belong in the same package for bench use.

Test Plan:
- PutFullData addr 0x000, data 0x0000_01B2, mask F -> reg_we_o one cycle with reg_addr 0x000 and wdata 0x1B2; d_valid 2 cycles after accept; d_opcode 0, d_error 0.
- Get addr 0x000 after baud=0x1B2, RD_LAT=1 -> reg_re_o one cycle; d_valid 3 cycles after accept; d_data 0x0000_00B2 (uart_core returns only 8 bits); d_opcode 1.
- Put addr 0x006 -> no strobe; d_error 1 the cycle after accept. Repeat with mask 4'h3, size 1 and opcode 3 -> each gives d_error 1 and no strobe.
- d_ready held low 5 cycles after a Get response -> d_valid and d_data stable for all 5; a_ready 0 and a second a_valid not accepted until the handshake completes.
- rst_ni pulsed low during WAIT_RD -> d_valid 0; a_ready 1 after release; no response for the dropped transaction. The next Put completes normally.
- With UART_TLUL_ADDR_CHECK_EN: Put to 0x5000_0004 -> d_error 1, no reg_we; Put to 0x4000_0004 -> normal write to reg_addr 0x004.

Source files
------------

// File: rtl/uart_tlul_pkg.sv
// uart_tlul_pkg: TL-UL opcodes, bridge states and the uart_core register map
package uart_tlul_pkg;
  localparam int UART_REG_AW = 12;
  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_RD,
    RESP
  } bridge_state_e;
  localparam logic [UART_REG_AW-1:0] UART_BAUD_ADDR   = 12'h000;
  localparam logic [UART_REG_AW-1:0] UART_CTRL_ADDR   = 12'h004;
  localparam logic [UART_REG_AW-1:0] UART_STATUS_ADDR = 12'h008;
  localparam logic [UART_REG_AW-1:0] UART_TXDATA_ADDR = 12'h00C;
  localparam logic [UART_REG_AW-1:0] UART_RXDATA_ADDR = 12'h010;
endpackage

// File: rtl/uart_tlul_bridge.sv
// uart_tlul_bridge: TL-UL device adapter driving uart_core register strobes (define UART_TLUL_ADDR_CHECK_EN to reject accesses outside the BASE_ADDR page)
module uart_tlul_bridge
  import uart_tlul_pkg::*;
#(
  parameter int          SRC_W     = 8,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_valid_i,
  input  logic [2:0]             a_opcode_i,
  input  logic [1:0]             a_size_i,
  input  logic [31:0]            a_address_i,
  input  logic [3:0]             a_mask_i,
  input  logic [31:0]            a_data_i,
  input  logic [SRC_W-1:0]       a_source_i,
  output logic                   a_ready_o,
  output logic                   d_valid_o,
  output logic [2:0]             d_opcode_o,
  output logic [1:0]             d_size_o,
  output logic [SRC_W-1:0]       d_source_o,
  output logic [31:0]            d_data_o,
  output logic                   d_error_o,
  input  logic                   d_ready_i,
  output logic [UART_REG_AW-1:0] reg_addr_o,
  output logic [31:0]            reg_wdata_o,
  output logic                   reg_we_o,
  output logic                   reg_re_o,
  input  logic [31:0]            reg_rdata_i
);
  bridge_state_e          state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   d_valid_q, d_valid_d;
  tl_d_op_e               d_opcode_q, d_opcode_d;
  logic [1:0]             d_size_q, d_size_d;
  logic [SRC_W-1:0]       d_source_q, d_source_d;
  logic [31:0]            d_data_q, d_data_d;
  logic                   d_error_q, d_error_d;
  logic [UART_REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]            reg_wdata_q, reg_wdata_d;
  logic                   reg_we_q, reg_we_d;
  logic                   reg_re_q, reg_re_d;
  logic                   is_put, is_get, addr_err, err;
`ifdef UART_TLUL_ADDR_CHECK_EN
  logic unused_base;
  assign unused_base = ^BASE_ADDR[11:0];
  assign addr_err = a_address_i[31:12] != BASE_ADDR[31:12];
`else
  logic unused_upper;
  assign unused_upper = ^{a_address_i[31:12], BASE_ADDR};
  assign addr_err = 1'b0;
`endif
  assign is_put = a_opcode_i == PutFullData || a_opcode_i == PutPartialData;
  assign is_get = a_opcode_i == Get;
  assign err = !(is_put || is_get) || a_size_i != 2'd2 || a_address_i[1:0] != 2'b00 ||
               (is_put && a_mask_i != 4'hF) || addr_err;
  // Next-state and next-output logic: accept, single strobe, read wait, hold response
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_data_d    = d_data_q;
    d_error_d   = d_error_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    case (state_q)
      IDLE: if (a_valid_i) begin
        state_d    = err ? RESP : ACCESS;
        d_valid_d  = err;
        d_error_d  = err;
        d_opcode_d = is_get ? AccessAckData : AccessAck;
        d_size_d   = a_size_i;
        d_source_d = a_source_i;
        d_data_d   = '0;
        if (!err) begin
          reg_addr_d  = a_address_i[UART_REG_AW-1:0];
          reg_wdata_d = a_data_i;
          reg_we_d    = is_put;
          reg_re_d    = is_get;
        end
      end
      ACCESS: begin
        state_d   = d_opcode_q == AccessAckData ? WAIT_RD : RESP;
        d_valid_d = d_opcode_q == AccessAck;
        cnt_d     = 2'(RD_LAT - 1);
      end
      WAIT_RD: if (cnt_q == 2'd0) begin
        state_d   = RESP;
        d_valid_d = 1'b1;
        d_data_d  = reg_rdata_i;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      RESP: if (d_ready_i) begin
        state_d   = IDLE;
        d_valid_d = 1'b0;
      end
    endcase
  end
  // State and registered outputs; reset drops any transaction in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= AccessAck;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_error_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_data_q    <= d_data_d;
      d_error_q   <= d_error_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
    end
  end
  assign a_ready_o   = state_q == IDLE;
  assign d_valid_o   = d_valid_q;
  assign d_opcode_o  = d_opcode_q;
  assign d_size_o    = d_size_q;
  assign d_source_o  = d_source_q;
  assign d_data_o    = d_data_q;
  assign d_error_o   = d_error_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
endmodule
